// File: rtl/sparse_pkg.sv
// Shared types and default widths for the sparse multiplier join/compare/MAC blocks.
// Widths here fix the pair_t layout; the join controller defaults to the same values.
package sparse_pkg;

   localparam int IDX_W_DEF = 3;
   localparam int PTR_W_DEF = 3;

   typedef struct packed {
      logic [PTR_W_DEF-1:0] a_pos;
      logic [PTR_W_DEF-1:0] b_pos;
      logic [IDX_W_DEF-1:0] idx;
   } pair_t;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } join_state_t;

endpackage

// File: rtl/sparse_join_ctrl_pair_fifo.sv
// First-word fall-through FIFO of matched pairs; extra pointer bit separates full from empty.
// Head reads as zero while empty so downstream never sees stale entries.
module pair_fifo
   import sparse_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic  clk,
   input  logic  rst_n,
   input  logic  i_push,
   input  logic  i_pop,
   input  pair_t i_din,
   output pair_t o_head,
   output logic  o_full,
   output logic  o_empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   pair_t       r_mem [DEPTH];
   logic [AW:0] r_wr_ptr;
   logic [AW:0] r_rd_ptr;
   logic        w_push;
   logic        w_pop;

   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   // Push is refused when full even if a pop lands in the same cycle.
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;
   assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
   end

endmodule

// File: rtl/sparse_join_ctrl.sv
// Merge-join scheduler: walks two sorted index lists and emits matching position pairs.
// state | meaning
// IDLE  | waiting for start, lengths latched on start
// RUN   | one compare/pointer step per cycle, stalls on match with full FIFO
// DRAIN | list exhausted, waiting for buffered pairs to be consumed
// DONE  | one-cycle done pulse
module sparse_join_ctrl
   import sparse_pkg::*;
#(
   parameter int IDX_W = IDX_W_DEF,
   parameter int PTR_W = PTR_W_DEF,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [PTR_W:0]   a_len,
   input  logic [PTR_W:0]   b_len,
   output logic [PTR_W-1:0] a_addr,
   input  logic [IDX_W-1:0] a_idx,
   output logic [PTR_W-1:0] b_addr,
   input  logic [IDX_W-1:0] b_idx,
   output logic             pair_valid,
   input  logic             pair_ready,
   output logic [PTR_W-1:0] pair_a,
   output logic [PTR_W-1:0] pair_b,
   output logic [IDX_W-1:0] pair_idx,
   output logic             busy,
   output logic             done,
   output logic [PTR_W:0]   match_count
);

   localparam logic [PTR_W:0] ONE = (PTR_W+1)'(1);

   join_state_t    r_state;
   join_state_t    w_state_nxt;
   logic [PTR_W:0] r_a_ptr, w_a_ptr_nxt;
   logic [PTR_W:0] r_b_ptr, w_b_ptr_nxt;
   logic [PTR_W:0] r_a_len, r_b_len;
   logic [PTR_W:0] r_match_count, w_cnt_nxt;
   logic           w_load;
   logic           w_push;
   logic           w_full;
   logic           w_empty;
   pair_t          w_din;
   pair_t          w_head;

   assign a_addr      = r_a_ptr[PTR_W-1:0];
   assign b_addr      = r_b_ptr[PTR_W-1:0];
   assign match_count = r_match_count;
   assign pair_valid  = ~w_empty;
   assign pair_a      = w_head.a_pos;
   assign pair_b      = w_head.b_pos;
   assign pair_idx    = w_head.idx;
   assign w_din       = '{a_pos: r_a_ptr[PTR_W-1:0], b_pos: r_b_ptr[PTR_W-1:0], idx: a_idx};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= IDLE;
         r_a_ptr       <= '0;
         r_b_ptr       <= '0;
         r_a_len       <= '0;
         r_b_len       <= '0;
         r_match_count <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_a_ptr       <= w_a_ptr_nxt;
         r_b_ptr       <= w_b_ptr_nxt;
         r_match_count <= w_cnt_nxt;
         if (w_load) begin
            r_a_len <= a_len;
            r_b_len <= b_len;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_a_ptr_nxt = r_a_ptr;
      w_b_ptr_nxt = r_b_ptr;
      w_cnt_nxt   = r_match_count;
      w_load      = 1'b0;
      w_push      = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_load      = 1'b1;
               w_a_ptr_nxt = '0;
               w_b_ptr_nxt = '0;
               w_cnt_nxt   = '0;
               w_state_nxt = (a_len == '0 || b_len == '0) ? DRAIN : RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (a_idx < b_idx) begin
               w_a_ptr_nxt = r_a_ptr + ONE;
            end else if (a_idx > b_idx) begin
               w_b_ptr_nxt = r_b_ptr + ONE;
            end else if (!w_full) begin
               w_push      = 1'b1;
               w_a_ptr_nxt = r_a_ptr + ONE;
               w_b_ptr_nxt = r_b_ptr + ONE;
               w_cnt_nxt   = r_match_count + ONE;
            end
            if (w_a_ptr_nxt == r_a_len || w_b_ptr_nxt == r_b_len) w_state_nxt = DRAIN;
         end
         DRAIN: begin
            busy = 1'b1;
            if (w_empty) w_state_nxt = DONE;
         end
         DONE: begin
            done        = 1'b1;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   pair_fifo #(
      .DEPTH(DEPTH)
   ) u_pair_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_push (w_push),
      .i_pop  (pair_valid & pair_ready),
      .i_din  (w_din),
      .o_head (w_head),
      .o_full (w_full),
      .o_empty(w_empty)
   );

endmodule

// File: tb/tb_sparse_join_ctrl.sv
// Directed table-driven bench for sparse_join_ctrl plus stall, reset and re-start sequences.
module tb_sparse_join_ctrl;

   localparam int IDX_W = 3;
   localparam int PTR_W = 3;
   localparam int DEPTH = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [PTR_W:0]   a_len = '0;
   logic [PTR_W:0]   b_len = '0;
   logic [PTR_W-1:0] a_addr, b_addr;
   logic [IDX_W-1:0] a_idx, b_idx;
   logic             pair_valid;
   logic             pair_ready = 1'b1;
   logic [PTR_W-1:0] pair_a, pair_b;
   logic [IDX_W-1:0] pair_idx;
   logic             busy, done;
   logic [PTR_W:0]   match_count;

   logic [2:0] a_mem [8];
   logic [2:0] b_mem [8];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   assign a_idx = a_mem[a_addr];
   assign b_idx = b_mem[b_addr];

   sparse_join_ctrl #(
      .IDX_W(IDX_W),
      .PTR_W(PTR_W),
      .DEPTH(DEPTH)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .a_len      (a_len),
      .b_len      (b_len),
      .a_addr     (a_addr),
      .a_idx      (a_idx),
      .b_addr     (b_addr),
      .b_idx      (b_idx),
      .pair_valid (pair_valid),
      .pair_ready (pair_ready),
      .pair_a     (pair_a),
      .pair_b     (pair_b),
      .pair_idx   (pair_idx),
      .busy       (busy),
      .done       (done),
      .match_count(match_count)
   );

   typedef struct {
      logic [7:0][2:0] a;
      logic [7:0][2:0] b;
      logic [3:0]      alen;
      logic [3:0]      blen;
      int              npairs;
      logic [7:0][8:0] pairs;
      int              busy_cyc;
   } vec_t;

   vec_t vecs [5];

   function automatic logic [7:0][2:0] pk8(input int e0, e1, e2, e3, e4, e5, e6, e7);
      logic [7:0][2:0] r;
      r[0] = 3'(e0); r[1] = 3'(e1); r[2] = 3'(e2); r[3] = 3'(e3);
      r[4] = 3'(e4); r[5] = 3'(e5); r[6] = 3'(e6); r[7] = 3'(e7);
      return r;
   endfunction

   function automatic logic [8:0] pr(input int pa, pb, ix);
      return {3'(pa), 3'(pb), 3'(ix)};
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic load_mem(input vec_t v);
      for (int i = 0; i < 8; i++) begin
         a_mem[i] = v.a[i];
         b_mem[i] = v.b[i];
      end
   endtask

   // Assumes start has already been taken; first sample is the current negedge.
   task automatic collect(input vec_t v, input string tag, input bit poke, output int n_busy);
      int  k = 0;
      bit  got_done = 1'b0;
      n_busy = 0;
      for (int cyc = 0; cyc < 300 && !got_done; cyc++) begin
         if (cyc > 0) @(negedge clk);
         start = (poke && (cyc == 2 || cyc == 4));
         if (busy) n_busy++;
         if (pair_valid && pair_ready) begin
            if (k < v.npairs)
               check($sformatf("%s_pair%0d", tag, k), int'({pair_a, pair_b, pair_idx}), int'(v.pairs[k]));
            else
               check({tag, "_extra_pair"}, k, v.npairs);
            k++;
         end
         if (done) begin
            got_done = 1'b1;
            check({tag, "_busy_in_done"}, int'(busy), 0);
         end
      end
      start = 1'b0;
      check({tag, "_done_seen"}, int'(got_done), 1);
      check({tag, "_npairs"}, k, v.npairs);
      check({tag, "_match_count"}, int'(match_count), v.npairs);
      @(negedge clk);
      check({tag, "_done_one_cycle"}, int'(done), 0);
      check({tag, "_count_held"}, int'(match_count), v.npairs);
   endtask

   task automatic run_join(input vec_t v, input string tag, input bit poke);
      int nb;
      load_mem(v);
      @(negedge clk);
      a_len = v.alen;
      b_len = v.blen;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({tag, "_busy_after_start"}, int'(busy), 1);
      collect(v, tag, poke, nb);
      check({tag, "_busy_cycles"}, nb, v.busy_cyc);
   endtask

   initial begin
      int nb;
      for (int i = 0; i < 5; i++) vecs[i].pairs = '0;
      // A={0,2,5,7}, B={1,2,3,7}
      vecs[0].a = pk8(0,2,5,7,0,0,0,0); vecs[0].b = pk8(1,2,3,7,0,0,0,0);
      vecs[0].alen = 4; vecs[0].blen = 4; vecs[0].npairs = 2; vecs[0].busy_cyc = 8;
      vecs[0].pairs[0] = pr(1,1,2); vecs[0].pairs[1] = pr(3,3,7);
      // empty A list
      vecs[1].a = pk8(0,1,2,3,4,5,6,7); vecs[1].b = pk8(0,1,2,3,4,5,6,7);
      vecs[1].alen = 0; vecs[1].blen = 5; vecs[1].npairs = 0; vecs[1].busy_cyc = 1;
      // disjoint lists: 7 RUN + 1 DRAIN
      vecs[2].a = pk8(0,2,4,6,0,0,0,0); vecs[2].b = pk8(1,3,5,7,0,0,0,0);
      vecs[2].alen = 4; vecs[2].blen = 4; vecs[2].npairs = 0; vecs[2].busy_cyc = 8;
      // B exhausts first, unequal lengths
      vecs[3].a = pk8(1,3,4,6,7,0,0,0); vecs[3].b = pk8(0,1,4,7,0,0,0,0);
      vecs[3].alen = 5; vecs[3].blen = 3; vecs[3].npairs = 2; vecs[3].busy_cyc = 6;
      vecs[3].pairs[0] = pr(0,1,1); vecs[3].pairs[1] = pr(2,2,4);
      // identical full-depth lists, consumer always ready
      vecs[4].a = pk8(0,1,2,3,4,5,6,7); vecs[4].b = pk8(0,1,2,3,4,5,6,7);
      vecs[4].alen = 8; vecs[4].blen = 8; vecs[4].npairs = 8; vecs[4].busy_cyc = 10;
      for (int i = 0; i < 8; i++) vecs[4].pairs[i] = pr(i,i,i);

      load_mem(vecs[0]);
      #12;
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_pair_valid", int'(pair_valid), 0);
      check("rst_match_count", int'(match_count), 0);
      check("rst_addrs", int'({a_addr, b_addr}), 0);
      check("rst_pair_fields", int'({pair_a, pair_b, pair_idx}), 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 5; i++) run_join(vecs[i], $sformatf("vec%0d", i), 1'b0);

      // backpressure: four pushes fill the FIFO, then the equal compare stalls
      load_mem(vecs[4]);
      pair_ready = 1'b0;
      @(negedge clk);
      a_len = 8; b_len = 8; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      check("stall_match_count", int'(match_count), 4);
      check("stall_a_addr", int'(a_addr), 4);
      check("stall_b_addr", int'(b_addr), 4);
      check("stall_busy", int'(busy), 1);
      check("stall_head", int'({pair_valid, pair_a, pair_b, pair_idx}), int'({1'b1, 9'd0}));
      pair_ready = 1'b1;
      collect(vecs[4], "stall", 1'b0, nb);

      // reset mid-join with two pairs buffered
      pair_ready = 1'b0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("pre_rst_count", int'(match_count), 2);
      check("pre_rst_valid", int'(pair_valid), 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", int'(pair_valid), 0);
      check("mid_rst_busy", int'(busy), 0);
      check("mid_rst_count", int'(match_count), 0);
      #1;
      rst_n = 1'b1;
      pair_ready = 1'b1;
      run_join(vecs[0], "after_rst", 1'b0);

      // start pulses during busy must not disturb the join or add a done
      run_join(vecs[0], "busy_start", 1'b1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check($sformatf("busy_start_quiet%0d", i), int'({busy, done}), 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
